// File: rtl/codec_loopback_checker.sv
// codec_loopback_checker: segment pattern generator feeding an encoder, plus a
// latency-aligned comparator on the decoder side with a HUNT/LOCKED lock FSM
// and a saturating error counter.
module codec_loopback_checker #(
  parameter int SEG_W    = 16,
  parameter int NSEG     = 4,
  parameter int CTRL_W   = 8,
  parameter int LOCK_CNT = 8,
  parameter int BAD_MAX  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            pat_mode,
  input  logic [CTRL_W-1:0]     ctrl_pat,
  output logic [SEG_W*NSEG-1:0] gen_data,
  output logic [CTRL_W-1:0]     gen_ctrl,
  input  logic [SEG_W*NSEG-1:0] dec_data,
  input  logic [CTRL_W-1:0]     dec_ctrl,
  input  logic                  dec_valid,
  input  logic [3:0]            lat_cfg,
  input  logic                  clr_count,
  output logic                  locked,
  output logic                  err_pulse,
  output logic [15:0]           err_count
);

  localparam int DATA_W = SEG_W * NSEG;
  localparam int WORD_W = CTRL_W + DATA_W;
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(BAD_MAX + 1);

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // The LFSR is always 16 bits wide; the segment register is resized in and out.
  function automatic logic [15:0] seg_to16(input logic [SEG_W-1:0] v);
    seg_to16 = '0;
    for (int unsigned i = 0; i < 16 && i < SEG_W; i++) seg_to16[i] = v[i];
  endfunction

  function automatic logic [SEG_W-1:0] seg_from16(input logic [15:0] v);
    seg_from16 = '0;
    for (int unsigned i = 0; i < 16 && i < SEG_W; i++) seg_from16[i] = v[i];
  endfunction

  logic [SEG_W-1:0]  seg;
  logic [SEG_W-1:0]  seg_next;
  logic [15:0]       lfsr_cur;
  logic [15:0]       lfsr_step;
  logic [WORD_W-1:0] cur_word;
  logic [WORD_W-1:0] exp_word;
  logic [WORD_W-1:0] hist [16];
  logic [3:0]        lat_q;
  logic [1:0]        mode_q;
  logic [3:0]        fill;
  logic              change;
  logic              qual;
  logic              match;
  logic              qual_r;
  logic              match_r;
  logic [0:0]        state;
  logic [GOOD_W-1:0] good_cnt;
  logic [BAD_W-1:0]  bad_cnt;

  // Fibonacci taps 16,14,13,11; an all-zero state steps straight to 1.
  assign lfsr_cur  = seg_to16(seg);
  assign lfsr_step = (lfsr_cur == 16'd0) ? 16'd1 :
                     {lfsr_cur[14:0], lfsr_cur[15] ^ lfsr_cur[13] ^ lfsr_cur[12] ^ lfsr_cur[10]};

  // Next segment value by pattern mode; hold while not enabled.
  always_comb begin
    seg_next = seg;
    if (enable) begin
      case (pat_mode)
        2'b01:   seg_next = '0;
        2'b10:   seg_next = seg_from16(lfsr_step);
        default: seg_next = seg + SEG_W'(1);
      endcase
    end
  end

  // Generator state: segment register and registered control value.
  always_ff @(posedge clock) begin
    if (reset) begin
      seg      <= '0;
      gen_ctrl <= '0;
    end else begin
      seg      <= seg_next;
      gen_ctrl <= ctrl_pat;
    end
  end

  assign gen_data = {NSEG{seg}};
  assign cur_word = {gen_ctrl, gen_data};

  // History line: hist[k] holds the generator word from k+1 cycles ago.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < 16; i++) hist[i] <= '0;
    end else begin
      hist[0] <= cur_word;
      for (int unsigned i = 1; i < 16; i++) hist[i] <= hist[i-1];
    end
  end

  // Expected word: current output for zero latency, else the history tap.
  always_comb begin
    exp_word = cur_word;
    if (lat_cfg != 4'd0) exp_word = hist[lat_cfg - 4'd1];
  end

  assign change = (lat_cfg != lat_q) || (pat_mode != mode_q);
  assign qual   = dec_valid && (fill >= lat_cfg) && !change;
  assign match  = ({dec_ctrl, dec_data} == exp_word);

  // Registered copies of the configuration for change detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      lat_q  <= '0;
      mode_q <= '0;
    end else begin
      lat_q  <= lat_cfg;
      mode_q <= pat_mode;
    end
  end

  // Compare pipeline stage; a config change discards the in-flight result.
  always_ff @(posedge clock) begin
    if (reset || change) begin
      qual_r  <= 1'b0;
      match_r <= 1'b0;
    end else begin
      qual_r  <= qual;
      match_r <= match;
    end
  end

  // Lock FSM, fill counter and error pulse, acting on the registered compare.
  always_ff @(posedge clock) begin
    if (reset || change) begin
      state     <= ST_HUNT;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      fill      <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (fill != 4'd15) fill <= fill + 4'd1;
      if (qual_r) begin
        if (state == ST_HUNT) begin
          if (match_r) begin
            if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
              state    <= ST_LOCKED;
              good_cnt <= '0;
              bad_cnt  <= '0;
            end else begin
              good_cnt <= good_cnt + GOOD_W'(1);
            end
          end else begin
            good_cnt <= '0;
          end
        end else begin
          if (!match_r) begin
            err_pulse <= 1'b1;
            if (bad_cnt == BAD_W'(BAD_MAX - 1)) begin
              state    <= ST_HUNT;
              good_cnt <= '0;
              bad_cnt  <= '0;
            end else begin
              bad_cnt <= bad_cnt + BAD_W'(1);
            end
          end else begin
            bad_cnt <= '0;
          end
        end
      end
    end
  end

  assign locked = (state == ST_LOCKED);

  // Saturating error counter; clear takes priority over a pending increment.
  always_ff @(posedge clock) begin
    if (reset || clr_count) begin
      err_count <= '0;
    end else if (err_pulse && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_codec_loopback_checker.sv
// Testbench for codec_loopback_checker: randomized stimulus against a
// cycle-level behavioural model; a second instance with a large BAD_MAX
// exercises error-counter saturation and segment wrap.
module tb_codec_loopback_checker;

  localparam int SEG_W    = 16;
  localparam int NSEG     = 4;
  localparam int CTRL_W   = 8;
  localparam int LOCK_CNT = 8;
  localparam int BAD_MAX  = 4;
  localparam int DATA_W   = SEG_W * NSEG;
  localparam int WORD_W   = CTRL_W + DATA_W;
  localparam int OBS_W    = WORD_W + 18;

  logic              clock;
  logic              reset;
  logic              enable;
  logic [1:0]        pat_mode;
  logic [CTRL_W-1:0] ctrl_pat;
  logic [DATA_W-1:0] gen_data;
  logic [CTRL_W-1:0] gen_ctrl;
  logic [DATA_W-1:0] dec_data;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_valid;
  logic [3:0]        lat_cfg;
  logic              clr_count;
  logic              locked;
  logic              err_pulse;
  logic [15:0]       err_count;

  logic              s_enable;
  logic [1:0]        s_mode;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_gen_data;
  logic [CTRL_W-1:0] s_gen_ctrl;
  logic [DATA_W-1:0] s_dec_data;
  logic [CTRL_W-1:0] s_dec_ctrl;
  logic              s_dec_valid;
  logic [3:0]        s_lat;
  logic              s_clr;
  logic              s_locked;
  logic              s_err_pulse;
  logic [15:0]       s_err_count;

  codec_loopback_checker #(
    .SEG_W(SEG_W), .NSEG(NSEG), .CTRL_W(CTRL_W), .LOCK_CNT(LOCK_CNT), .BAD_MAX(BAD_MAX)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .pat_mode(pat_mode), .ctrl_pat(ctrl_pat),
    .gen_data(gen_data), .gen_ctrl(gen_ctrl), .dec_data(dec_data), .dec_ctrl(dec_ctrl),
    .dec_valid(dec_valid), .lat_cfg(lat_cfg), .clr_count(clr_count), .locked(locked),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  codec_loopback_checker #(
    .SEG_W(SEG_W), .NSEG(NSEG), .CTRL_W(CTRL_W), .LOCK_CNT(LOCK_CNT), .BAD_MAX(100000)
  ) sat (
    .clock(clock), .reset(reset), .enable(s_enable), .pat_mode(s_mode), .ctrl_pat(s_ctrl),
    .gen_data(s_gen_data), .gen_ctrl(s_gen_ctrl), .dec_data(s_dec_data), .dec_ctrl(s_dec_ctrl),
    .dec_valid(s_dec_valid), .lat_cfg(s_lat), .clr_count(s_clr), .locked(s_locked),
    .err_pulse(s_err_pulse), .err_count(s_err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state.
  logic [SEG_W-1:0]  m_seg;
  logic [CTRL_W-1:0] m_ctrl;
  logic [WORD_W-1:0] m_log[$];
  int                m_fill, m_good, m_bad, m_cnt;
  bit                m_locked, m_pulse, m_pq, m_pm;
  logic [3:0]        m_prev_lat;
  logic [1:0]        m_prev_mode;

  // Decoder emulation controls.
  int                true_lat;
  bit                want_valid;
  logic [WORD_W-1:0] corrupt;

  function automatic logic [WORD_W-1:0] cur_word();
    return {m_ctrl, {NSEG{m_seg}}};
  endfunction

  function automatic logic [WORD_W-1:0] word_ago(input int k);
    if (k == 0) return cur_word();
    if (m_log.size() >= k) return m_log[m_log.size() - k];
    return '0;
  endfunction

  function automatic logic [SEG_W-1:0] next_seg(input logic [SEG_W-1:0] s, input logic [1:0] mode);
    int v;
    int fb;
    v = int'(s);
    case (mode)
      2'b01: return '0;
      2'b10: begin
        if (v == 0) return 16'd1;
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return SEG_W'(((v << 1) | fb) & 16'hFFFF);
      end
      default: return SEG_W'((v + 1) % 65536);
    endcase
  endfunction

  function automatic logic [OBS_W-1:0] obs_vec();
    return {gen_ctrl, gen_data, locked, err_pulse, err_count};
  endfunction

  function automatic logic [OBS_W-1:0] mdl_vec();
    return {m_ctrl, {NSEG{m_seg}}, m_locked, m_pulse, 16'(m_cnt)};
  endfunction

  // Drive the decoder from the model, advance the model over one edge, wait the edge.
  task automatic step();
    logic [WORD_W-1:0] d, ex, cur;
    int lat, nc;
    bit chg, q, mt;
    d = word_ago(true_lat) ^ corrupt;
    dec_ctrl  = d[WORD_W-1:DATA_W];
    dec_data  = d[DATA_W-1:0];
    dec_valid = want_valid && (m_log.size() >= true_lat);
    if (reset) begin
      m_seg = '0; m_ctrl = '0; m_log.delete();
      m_fill = 0; m_good = 0; m_bad = 0; m_cnt = 0;
      m_locked = 0; m_pulse = 0; m_pq = 0; m_pm = 0;
      m_prev_lat = '0; m_prev_mode = '0;
    end else begin
      cur = cur_word();
      lat = int'(lat_cfg);
      ex  = word_ago(lat);
      chg = (lat_cfg != m_prev_lat) || (pat_mode != m_prev_mode);
      q   = dec_valid && (m_fill >= lat) && !chg;
      mt  = ({dec_ctrl, dec_data} === ex);
      nc  = clr_count ? 0 : ((m_pulse && m_cnt < 65535) ? m_cnt + 1 : m_cnt);
      if (chg) begin
        m_locked = 0; m_good = 0; m_bad = 0; m_fill = 0; m_pq = 0; m_pm = 0; m_pulse = 0;
      end else begin
        m_fill  = (m_fill < 15) ? m_fill + 1 : 15;
        m_pulse = 0;
        if (m_pq) begin
          if (!m_locked) begin
            if (m_pm) begin
              m_good++;
              if (m_good == LOCK_CNT) begin m_locked = 1; m_good = 0; m_bad = 0; end
            end else m_good = 0;
          end else begin
            if (!m_pm) begin
              m_pulse = 1;
              m_bad++;
              if (m_bad == BAD_MAX) begin m_locked = 0; m_good = 0; m_bad = 0; end
            end else m_bad = 0;
          end
        end
        m_pq = q; m_pm = mt;
      end
      m_cnt = nc;
      m_log.push_back(cur);
      if (m_log.size() > 20) void'(m_log.pop_front());
      if (enable) m_seg = next_seg(m_seg, pat_mode);
      m_ctrl = ctrl_pat;
      m_prev_lat = lat_cfg; m_prev_mode = pat_mode;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ctrl_pat = CTRL_W'($urandom);
      step();
      vectors++;
      if (obs_vec() !== mdl_vec()) begin
        miscompares++; $display("FAIL reset cyc %0d: got %h want %h", i, obs_vec(), mdl_vec());
      end
    end
    vectors++;
    if ({gen_data, gen_ctrl, locked, err_pulse, err_count} !== '0) begin
      miscompares++; $display("FAIL reset_zero: got %h want 0", {gen_data, gen_ctrl, locked, err_pulse, err_count});
    end
    reset = 1'b0;
  endtask

  task automatic test_lock_inc();
    pat_mode = 2'b00; lat_cfg = 4'd3; true_lat = 3; enable = 1'b1; want_valid = 1'b1; corrupt = '0;
    for (int i = 0; i < 40; i++) begin
      ctrl_pat = CTRL_W'($urandom);
      step();
      vectors++;
      if (obs_vec() !== mdl_vec()) begin
        miscompares++; $display("FAIL lock_inc cyc %0d: got %h want %h", i, obs_vec(), mdl_vec());
      end
    end
    vectors++;
    if (locked !== 1'b1 || err_count !== 16'd0) begin
      miscompares++; $display("FAIL lock_inc_final: got locked=%b cnt=%0d want 1/0", locked, err_count);
    end
  endtask

  task automatic test_single_flip();
    for (int i = 0; i < 12; i++) begin
      corrupt = '0;
      if (i == 1) corrupt[$urandom_range(DATA_W-1, 0)] = 1'b1;
      ctrl_pat = CTRL_W'($urandom);
      step();
      vectors++;
      if (obs_vec() !== mdl_vec()) begin
        miscompares++; $display("FAIL single_flip cyc %0d: got %h want %h", i, obs_vec(), mdl_vec());
      end
    end
    vectors++;
    if (locked !== 1'b1 || err_count !== 16'd1) begin
      miscompares++; $display("FAIL single_flip_final: got locked=%b cnt=%0d want 1/1", locked, err_count);
    end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 30; i++) begin
      corrupt = (i < 4) ? WORD_W'(1) << $urandom_range(DATA_W-1, 0) : '0;
      ctrl_pat = CTRL_W'($urandom);
      step();
      vectors++;
      if (obs_vec() !== mdl_vec()) begin
        miscompares++; $display("FAIL burst cyc %0d: got %h want %h", i, obs_vec(), mdl_vec());
      end
      if (i == 5) begin
        vectors++;
        if (locked !== 1'b0) begin
          miscompares++; $display("FAIL burst_drop: got locked=%b want 0", locked);
        end
      end
    end
    vectors++;
    if (locked !== 1'b1 || err_count !== 16'd5) begin
      miscompares++; $display("FAIL burst_final: got locked=%b cnt=%0d want 1/5", locked, err_count);
    end
  endtask

  task automatic test_wrong_lat();
    corrupt = '0;
    lat_cfg = 4'd2;
    for (int i = 0; i < 70; i++) begin
      if (i == 35) lat_cfg = 4'd3;
      ctrl_pat = CTRL_W'($urandom);
      step();
      vectors++;
      if (obs_vec() !== mdl_vec()) begin
        miscompares++; $display("FAIL wrong_lat cyc %0d: got %h want %h", i, obs_vec(), mdl_vec());
      end
      if (i == 34) begin
        vectors++;
        if (locked !== 1'b0 || err_count !== 16'd5) begin
          miscompares++; $display("FAIL wrong_lat_hunt: got locked=%b cnt=%0d want 0/5", locked, err_count);
        end
      end
    end
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++; $display("FAIL wrong_lat_relock: got locked=%b want 1", locked);
    end
  endtask

  task automatic test_mid_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if (locked !== 1'b0 || gen_data !== '0 || err_count !== 16'd0) begin
      miscompares++; $display("FAIL mid_reset: got locked=%b data=%h cnt=%0d want 0/0/0", locked, gen_data, err_count);
    end
    for (int i = 0; i < 5; i++) begin
      ctrl_pat = CTRL_W'($urandom);
      step();
      vectors++;
      if (obs_vec() !== mdl_vec()) begin
        miscompares++; $display("FAIL mid_reset cyc %0d: got %h want %h", i, obs_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_lfsr();
    pat_mode = 2'b10; lat_cfg = 4'd0; true_lat = 0; corrupt = '0;
    for (int i = 0; i < 70; i++) begin
      enable = i[0];
      want_valid = ($urandom_range(3, 0) != 0);
      ctrl_pat = CTRL_W'($urandom);
      step();
      vectors++;
      if (obs_vec() !== mdl_vec()) begin
        miscompares++; $display("FAIL lfsr cyc %0d: got %h want %h", i, obs_vec(), mdl_vec());
      end
    end
    vectors++;
    if (locked !== 1'b1 || err_count !== 16'd0) begin
      miscompares++; $display("FAIL lfsr_lock: got locked=%b cnt=%0d want 1/0", locked, err_count);
    end
    want_valid = 1'b0;
    corrupt = '1;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (obs_vec() !== mdl_vec()) begin
        miscompares++; $display("FAIL lfsr_invalid cyc %0d: got %h want %h", i, obs_vec(), mdl_vec());
      end
    end
    vectors++;
    if (locked !== 1'b1 || err_count !== 16'd0) begin
      miscompares++; $display("FAIL lfsr_invalid_hold: got locked=%b cnt=%0d want 1/0", locked, err_count);
    end
    corrupt = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(39, 0) == 0) pat_mode = 2'($urandom);
      if ($urandom_range(29, 0) == 0) begin
        true_lat = $urandom_range(15, 0);
        lat_cfg  = 4'(true_lat);
        if ($urandom_range(3, 0) == 0) lat_cfg = 4'($urandom);
      end
      enable     = ($urandom_range(4, 0) != 0);
      want_valid = ($urandom_range(5, 0) != 0);
      clr_count  = ($urandom_range(49, 0) == 0);
      corrupt    = '0;
      if ($urandom_range(11, 0) == 0) corrupt[$urandom_range(WORD_W-1, 0)] = 1'b1;
      ctrl_pat = CTRL_W'($urandom);
      step();
      vectors++;
      if (obs_vec() !== mdl_vec()) begin
        miscompares++; $display("FAIL random cyc %0d: got %h want %h", i, obs_vec(), mdl_vec());
      end
    end
    clr_count = 1'b0;
    corrupt = '0;
  endtask

  task automatic test_saturation();
    logic [SEG_W-1:0]  s_seg;
    logic [DATA_W-1:0] flip;
    s_seg = '0;
    flip  = '0;
    s_enable = 1'b1;
    s_dec_valid = 1'b1;
    for (int i = 0; i < 65620; i++) begin
      if (i == 12) begin
        vectors++;
        if (s_locked !== 1'b1 || s_err_count !== 16'd0) begin
          miscompares++; $display("FAIL sat_lock: got locked=%b cnt=%0d want 1/0", s_locked, s_err_count);
        end
        flip = DATA_W'(1);
      end
      s_dec_data = {NSEG{s_seg}} ^ flip;
      @(posedge clock);
      s_seg = s_seg + SEG_W'(1);
      #1;
      vectors++;
      if (s_gen_data !== {NSEG{s_seg}}) begin
        miscompares++; $display("FAIL sat_gen cyc %0d: got %h want %h", i, s_gen_data, {NSEG{s_seg}});
      end
    end
    vectors++;
    if (s_err_count !== 16'hFFFF || s_locked !== 1'b1 || s_err_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_hold: got cnt=%h locked=%b pulse=%b want FFFF/1/1", s_err_count, s_locked, s_err_pulse);
    end
    s_clr = 1'b1;
    s_dec_data = {NSEG{s_seg}} ^ flip;
    @(posedge clock);
    s_seg = s_seg + SEG_W'(1);
    #1;
    s_clr = 1'b0;
    vectors++;
    if (s_err_count !== 16'd0) begin
      miscompares++; $display("FAIL sat_clear: got %h want 0000", s_err_count);
    end
    s_dec_data = {NSEG{s_seg}} ^ flip;
    @(posedge clock);
    #1;
    vectors++;
    if (s_err_count !== 16'd1) begin
      miscompares++; $display("FAIL sat_after_clear: got %h want 0001", s_err_count);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; pat_mode = 2'b00; ctrl_pat = '0;
    dec_data = '0; dec_ctrl = '0; dec_valid = 1'b0; lat_cfg = 4'd0; clr_count = 1'b0;
    s_enable = 1'b0; s_mode = 2'b00; s_ctrl = '0; s_dec_data = '0; s_dec_ctrl = '0;
    s_dec_valid = 1'b0; s_lat = 4'd0; s_clr = 1'b0;
    true_lat = 0; want_valid = 1'b0; corrupt = '0;
    m_seg = '0; m_ctrl = '0; m_fill = 0; m_good = 0; m_bad = 0; m_cnt = 0;
    m_locked = 0; m_pulse = 0; m_pq = 0; m_pm = 0; m_prev_lat = '0; m_prev_mode = '0;
    @(negedge clock);
    test_reset();
    test_lock_inc();
    test_single_flip();
    test_burst();
    test_wrong_lat();
    test_mid_reset();
    test_lfsr();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
